btn_press_decoder: RTL and testbench

Classifies a debounced, clock-synchronous button level into one-cycle event pulses: short press, long press and double click. Sits directly downstream of the button debouncer and consumes its clean level output. Its pulses and wrapping event counter feed the LED indicator logic. Timing thresholds are in clock cycles and set by parameters.

---
 rtl/btn_press_decoder.sv | 89 ++++++++
 tb/tb_btn_press_decoder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/btn_press_decoder.sv
// btn_press_decoder: turns a debounced button level into one-cycle short/long/double-click pulses.
// Double-click detection (WAIT_GAP/PRESS2) is compiled in only when BTN_DOUBLE_EN is defined.
module btn_press_decoder #(
  parameter int CNT_BW     = 11,
  parameter int LONG_TICKS = 1000,
  parameter int GAP_TICKS  = 300
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       btn,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       double_pulse,
  output logic [3:0] event_cnt,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, PRESS, WAIT_GAP, PRESS2, HOLD} state_t;
  localparam logic [CNT_BW-1:0] L_LAST = CNT_BW'(LONG_TICKS - 1);
`ifdef BTN_DOUBLE_EN
  localparam logic [CNT_BW-1:0] G_LAST = CNT_BW'(GAP_TICKS - 1);
`else
  logic w_unused_gap;
  assign w_unused_gap = ^GAP_TICKS;
`endif
  state_t            r_state, w_next;
  logic [CNT_BW-1:0] r_timer;
  logic              w_short, w_long, w_double, w_inc;
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      double_pulse <= 1'b0;
      event_cnt    <= '0;
      busy         <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_timer      <= w_inc ? r_timer + 1'b1 : '0;
      short_pulse  <= w_short;
      long_pulse   <= w_long;
      double_pulse <= w_double;
      event_cnt    <= event_cnt + 4'(w_short | w_long | w_double);
      busy         <= w_next != IDLE;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = btn ? PRESS : IDLE;
`ifdef BTN_DOUBLE_EN
      PRESS:    w_next = !btn ? WAIT_GAP : (r_timer == L_LAST) ? HOLD : PRESS;
      WAIT_GAP: w_next = btn ? PRESS2 : (r_timer == G_LAST) ? IDLE : WAIT_GAP;
      PRESS2:   w_next = !btn ? IDLE : (r_timer == L_LAST) ? HOLD : PRESS2;
`else
      PRESS:    w_next = !btn ? IDLE : (r_timer == L_LAST) ? HOLD : PRESS;
`endif
      HOLD:     w_next = btn ? HOLD : IDLE;
      default:  w_next = IDLE;
    endcase
  end
  // The timer only runs while staying in a timed state, so every state entry sees it at 0.
  always_comb begin
    w_short  = 1'b0;
    w_long   = 1'b0;
    w_double = 1'b0;
    w_inc    = 1'b0;
    case (r_state)
      PRESS: begin
        w_long = btn && r_timer == L_LAST;
        w_inc  = btn && r_timer != L_LAST;
`ifndef BTN_DOUBLE_EN
        w_short = !btn;
`endif
      end
`ifdef BTN_DOUBLE_EN
      WAIT_GAP: begin
        w_short = !btn && r_timer == G_LAST;
        w_inc   = !btn && r_timer != G_LAST;
      end
      PRESS2: begin
        w_double = !btn || r_timer == L_LAST;
        w_inc    = btn && r_timer != L_LAST;
      end
`endif
      default: w_inc = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_btn_press_decoder.sv
// tb_btn_press_decoder: directed-step bench for btn_press_decoder (CNT_BW=4, LONG_TICKS=8, GAP_TICKS=4).
// Expectations follow the BTN_DOUBLE_EN setting the bench is compiled with.
module tb_btn_press_decoder;
  logic       clk = 1'b0, aclr = 1'b1, btn = 1'b0;
  logic       short_pulse, long_pulse, double_pulse, busy;
  logic [3:0] event_cnt;
  int checks = 0, errors = 0, n_s = 0, n_l = 0, n_d = 0, exp_cnt = 0, s0 = 0;
  logic [8:0] pat;
`ifdef BTN_DOUBLE_EN
  localparam bit DBL    = 1'b1;
  localparam int SP_LAT = 5;
`else
  localparam bit DBL    = 1'b0;
  localparam int SP_LAT = 1;
`endif
  btn_press_decoder #(.CNT_BW(4), .LONG_TICKS(8), .GAP_TICKS(4)) dut (
    .clk(clk), .aclr(aclr), .btn(btn), .short_pulse(short_pulse), .long_pulse(long_pulse),
    .double_pulse(double_pulse), .event_cnt(event_cnt), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic b);
    btn = b;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    n_s += int'(short_pulse);
    n_l += int'(long_pulse);
    n_d += int'(double_pulse);
    checks++;
    assert ($countones({short_pulse, long_pulse, double_pulse}) <= 1) else begin
      errors++;
      $error("FAIL one_pulse: observed %b expected at most one high", {short_pulse, long_pulse, double_pulse});
    end
  end
  initial begin
    #1 aclr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(i[0]);
      check("reset_outs", {short_pulse, long_pulse, double_pulse, event_cnt, busy}, 8'h00);
    end
    aclr = 1'b1;
    tick(0);
    check("idle_outs", {short_pulse, long_pulse, double_pulse, event_cnt, busy}, 8'h00);
    // short press
    tick(1);
    check("busy_rise", busy, 1);
    repeat (2) tick(1);
    for (int i = 1; i <= 6; i++) begin
      tick(0);
      check("short_timing", short_pulse, 8'(i == SP_LAT));
      if (i == SP_LAT) begin
        check("short_cnt", event_cnt, 1);
        check("short_busy", busy, 0);
      end
    end
    exp_cnt = 1;
    // long press with hold
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      check("long_timing", long_pulse, 8'(i == 9));
      check("long_busy", busy, 1);
    end
    exp_cnt = 2;
    check("long_cnt", event_cnt, 8'(exp_cnt));
    for (int i = 1; i <= 6; i++) begin
      tick(0);
      check("hold_release", {short_pulse, long_pulse, double_pulse}, 0);
      if (i == 1) check("hold_busy", busy, 0);
    end
    // double click 1x3, 0x2, 1x3, 0
    pat = 9'b011100111;
    for (int i = 0; i < 9; i++) begin
      tick(pat[i]);
      check("double_timing", double_pulse, 8'(DBL && i == 8));
      check("double_short", short_pulse, 8'(!DBL && (i == 3 || i == 8)));
    end
    for (int i = 0; i < 6; i++) begin
      tick(0);
      check("double_after", {short_pulse, long_pulse, double_pulse}, 0);
    end
    exp_cnt += DBL ? 1 : 2;
    check("double_cnt", event_cnt, 8'(exp_cnt));
    check("double_total", 8'(n_d), 8'(DBL ? 1 : 0));
    // sixteen short presses, counter wraps
    s0 = n_s;
    for (int p = 0; p < 16; p++) begin
      tick(1);
      tick(1);
      repeat (6) tick(0);
      exp_cnt = (exp_cnt + 1) % 16;
      check("wrap_cnt", event_cnt, 8'(exp_cnt));
    end
    check("wrap_shorts", 8'(n_s - s0), 16);
    check("long_total", 8'(n_l), 1);
    // reset asserted during PRESS
    repeat (3) tick(1);
    aclr = 1'b0;
    #1;
    check("async_reset", {short_pulse, long_pulse, double_pulse, event_cnt, busy}, 8'h00);
    repeat (2) begin
      tick(1);
      check("mid_reset", {short_pulse, long_pulse, double_pulse, event_cnt, busy}, 8'h00);
    end
    s0 = n_s + n_l + n_d;
    btn = 1'b0;
    aclr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(0);
      check("post_reset", {short_pulse, long_pulse, double_pulse, event_cnt, busy}, 8'h00);
    end
    check("post_reset_pulses", 8'(n_s + n_l + n_d - s0), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
